// File: rtl/exc_pkg.sv
// Shared types for the exception sequencer: exc_flags bit positions,
// CP0 Cause.ExcCode values, sequencer FSM states and BadVAddr source select.
package exc_pkg;

    localparam int FLG_ADEL_IF = 0;
    localparam int FLG_RI      = 1;
    localparam int FLG_OV      = 2;
    localparam int FLG_SYS     = 3;
    localparam int FLG_BP      = 4;
    localparam int FLG_ADEL_D  = 5;
    localparam int FLG_ADES    = 6;
    localparam int FLG_ERET    = 7;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        BADV_NONE = 2'd0,
        BADV_IF   = 2'd1,
        BADV_MEM  = 2'd2
    } badv_sel_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder for M-stage exception/interrupt events.
// Order: Int, AdEL-fetch, RI, Ov, Sys, Bp, AdEL-data, AdES, ERET.
// ERET is only reported when no exception or interrupt is present.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [7:0] i_flags,
    input  logic       i_int,
    output logic       o_hit,
    output logic       o_is_eret,
    output exc_code_t  o_code,
    output badv_sel_t  o_badv_sel
);

    // Pick the highest-priority source and its ExcCode / BadVAddr source.
    always_comb begin
        o_hit      = i_int | (|i_flags);
        o_is_eret  = 1'b0;
        o_code     = EXC_INT;
        o_badv_sel = BADV_NONE;
        if (i_int) begin
            o_code = EXC_INT;
        end else if (i_flags[FLG_ADEL_IF]) begin
            o_code     = EXC_ADEL;
            o_badv_sel = BADV_IF;
        end else if (i_flags[FLG_RI]) begin
            o_code = EXC_RI;
        end else if (i_flags[FLG_OV]) begin
            o_code = EXC_OV;
        end else if (i_flags[FLG_SYS]) begin
            o_code = EXC_SYS;
        end else if (i_flags[FLG_BP]) begin
            o_code = EXC_BP;
        end else if (i_flags[FLG_ADEL_D]) begin
            o_code     = EXC_ADEL;
            o_badv_sel = BADV_MEM;
        end else if (i_flags[FLG_ADES]) begin
            o_code     = EXC_ADES;
            o_badv_sel = BADV_MEM;
        end else if (i_flags[FLG_ERET]) begin
            o_is_eret = 1'b1;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception sequencer in front of CP0: samples M-stage events in IDLE,
// drains an outstanding data-bus transaction (bounded by DRAIN_MAX),
// issues a one-cycle CP0 commit and holds a PC redirect until fetch accepts.
// All outputs are registered from the next state, so the strobes line up
// with the state they belong to.
// Optional: define EXC_SEQ_STATS_EN to enable the exc_count/eret_count
// counters; otherwise those ports are tied to zero.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'hbfc00380,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [7:0]  exc_flags,
    input  logic [31:0] badv_if,
    input  logic [31:0] badv_mem,
    input  logic        int_pending,
    input  logic        mem_busy,
    input  logic [31:0] epc_in,
    output logic        exc_req,
    output logic        eret_req,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic        badv_we,
    output logic [31:0] badv,
    output logic        stall_all,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        drain_timeout,
    output logic [31:0] exc_count,
    output logic [15:0] eret_count
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_eret;
    logic             r_badv_vld;
    logic             w_hit;
    logic             w_enc_eret;
    exc_code_t        w_code;
    badv_sel_t        w_badv_sel;
    logic             w_event;
    logic             w_timeout;
    logic             w_eret_cur;
    logic             w_we_cur;

    exc_prio_enc u_enc (
        .i_flags    (exc_flags),
        .i_int      (int_pending),
        .o_hit      (w_hit),
        .o_is_eret  (w_enc_eret),
        .o_code     (w_code),
        .o_badv_sel (w_badv_sel)
    );

    assign w_event = valid_m & w_hit;
    // On the IDLE->COMMIT hop the capture registers are loaded in the same
    // edge, so take the kind of commit straight from the encoder there.
    assign w_eret_cur = (r_state == IDLE) ? w_enc_eret : r_is_eret;
    assign w_we_cur   = (r_state == IDLE) ? (w_badv_sel != BADV_NONE) : r_badv_vld;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; inputs other than mem_busy/redirect_ready only matter in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_event) w_state_nxt = mem_busy ? DRAIN : COMMIT;
            end
            DRAIN: begin
                if (!mem_busy) begin
                    w_state_nxt = COMMIT;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = COMMIT;
                    w_timeout   = 1'b1;
                end
            end
            COMMIT:   w_state_nxt = REDIRECT;
            REDIRECT: begin
                if (redirect_ready) w_state_nxt = IDLE;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Drain counter: holds the number of DRAIN cycles elapsed including the current one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= CNT_W'(1);
        end else if (r_state == DRAIN) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Capture the winning event's CP0 fields when it is accepted in IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_code   <= '0;
            exc_epc    <= '0;
            exc_bd     <= 1'b0;
            badv       <= '0;
            r_is_eret  <= 1'b0;
            r_badv_vld <= 1'b0;
        end else if (r_state == IDLE && w_event) begin
            exc_code   <= w_code;
            exc_epc    <= bd_m ? (pc_m - 32'd4) : pc_m;
            exc_bd     <= bd_m;
            badv       <= (w_badv_sel == BADV_IF)  ? badv_if  :
                          (w_badv_sel == BADV_MEM) ? badv_mem : 32'd0;
            r_is_eret  <= w_enc_eret;
            r_badv_vld <= (w_badv_sel != BADV_NONE);
        end
    end

    // Strobes, stall/flush, redirect and the sticky timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_req        <= 1'b0;
            eret_req       <= 1'b0;
            badv_we        <= 1'b0;
            stall_all      <= 1'b0;
            flush_all      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            drain_timeout  <= 1'b0;
        end else begin
            exc_req        <= (w_state_nxt == COMMIT) & ~w_eret_cur;
            eret_req       <= (w_state_nxt == COMMIT) &  w_eret_cur;
            badv_we        <= (w_state_nxt == COMMIT) & ~w_eret_cur & w_we_cur;
            stall_all      <= (w_state_nxt == DRAIN);
            flush_all      <= (w_state_nxt == COMMIT) | (w_state_nxt == REDIRECT);
            redirect_valid <= (w_state_nxt == REDIRECT);
            drain_timeout  <= drain_timeout | w_timeout;
            if (r_state == COMMIT) redirect_pc <= r_is_eret ? epc_in : VEC_BASE;
        end
    end

`ifdef EXC_SEQ_STATS_EN
    logic [31:0] r_exc_count;
    logic [15:0] r_eret_count;

    // Commit counters, wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exc_count  <= '0;
            r_eret_count <= '0;
        end else begin
            if (exc_req)  r_exc_count  <= r_exc_count + 32'd1;
            if (eret_req) r_eret_count <= r_eret_count + 16'd1;
        end
    end

    assign exc_count  = r_exc_count;
    assign eret_count = r_eret_count;
`else
    assign exc_count  = 32'd0;
    assign eret_count = 16'd0;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: table of events with expected CP0 commits pushed
// to a scoreboard queue and popped at the commit strobe, plus hand-written
// sequences for drain timeout, mid-sequence reset and the commit counters.
module tb_exc_sequencer;

    localparam logic [31:0] VEC = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [7:0]  exc_flags;
    logic [31:0] badv_if;
    logic [31:0] badv_mem;
    logic        int_pending;
    logic        mem_busy;
    logic [31:0] epc_in;
    logic        exc_req;
    logic        eret_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        badv_we;
    logic [31:0] badv;
    logic        stall_all;
    logic        flush_all;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        drain_timeout;
    logic [31:0] exc_count;
    logic [15:0] eret_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [7:0]  flags;
        logic [31:0] bif;
        logic [31:0] bmem;
        logic        intp;
        logic [31:0] epc_in;
        int          busy;
        int          rdy;
        logic        e_eret;
        logic [4:0]  e_code;
        logic [31:0] e_epc;
        logic        e_bd;
        logic        e_we;
        logic [31:0] e_badv;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t tbl[11];
    vec_t sb[$];

    exc_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .valid_m        (valid_m),
        .pc_m           (pc_m),
        .bd_m           (bd_m),
        .exc_flags      (exc_flags),
        .badv_if        (badv_if),
        .badv_mem       (badv_mem),
        .int_pending    (int_pending),
        .mem_busy       (mem_busy),
        .epc_in         (epc_in),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .exc_code       (exc_code),
        .exc_epc        (exc_epc),
        .exc_bd         (exc_bd),
        .badv_we        (badv_we),
        .badv           (badv),
        .stall_all      (stall_all),
        .flush_all      (flush_all),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .drain_timeout  (drain_timeout),
        .exc_count      (exc_count),
        .eret_count     (eret_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic bd,
                                input logic [7:0] fl, input logic [31:0] bif,
                                input logic [31:0] bmem, input logic ip,
                                input logic [31:0] ein, input int busy, input int rdy,
                                input logic ee, input logic [4:0] ec,
                                input logic [31:0] eepc, input logic ebd,
                                input logic ewe, input logic [31:0] ebadv);
        vec_t r;
        r.valid = v;   r.pc = pc;     r.bd = bd;       r.flags = fl;
        r.bif = bif;   r.bmem = bmem; r.intp = ip;     r.epc_in = ein;
        r.busy = busy; r.rdy = rdy;   r.e_eret = ee;   r.e_code = ec;
        r.e_epc = eepc; r.e_bd = ebd; r.e_we = ewe;    r.e_badv = ebadv;
        r.e_rpc = ee ? ein : VEC;
        return r;
    endfunction

    task automatic clear_event();
        valid_m     = 1'b0;
        exc_flags   = 8'h00;
        int_pending = 1'b0;
        bd_m        = 1'b0;
        pc_m        = 32'h1234_5678;
        badv_if     = 32'hffff_ffff;
        badv_mem    = 32'hffff_ffff;
    endtask

    // Full event -> commit -> redirect -> handshake sequence; starts and ends just after a negedge.
    task automatic run_seq(input vec_t v);
        vec_t e;
        int   t;
        valid_m     = v.valid;
        pc_m        = v.pc;
        bd_m        = v.bd;
        exc_flags   = v.flags;
        badv_if     = v.bif;
        badv_mem    = v.bmem;
        int_pending = v.intp;
        mem_busy    = (v.busy > 0);
        epc_in      = 32'hdead_beef;
        sb.push_back(v);
        @(negedge clk);
        clear_event();
        for (int i = 0; i < v.busy; i++) begin
            chk1("stall_drain", stall_all, 1'b1);
            chk1("no_early_strobe", exc_req | eret_req, 1'b0);
            if (i == v.busy - 1) mem_busy = 1'b0;
            @(negedge clk);
        end
        t = 0;
        while (!(exc_req || eret_req) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk1("strobe", exc_req | eret_req, 1'b1);
        e = sb.pop_front();
        chk1("exc_req", exc_req, ~e.e_eret);
        chk1("eret_req", eret_req, e.e_eret);
        chk1("flush_commit", flush_all, 1'b1);
        chk1("stall_commit", stall_all, 1'b0);
        chk1("rv_commit", redirect_valid, 1'b0);
        if (!e.e_eret) begin
            chk32("exc_code", {27'd0, exc_code}, {27'd0, e.e_code});
            chk32("exc_epc", exc_epc, e.e_epc);
            chk1("exc_bd", exc_bd, e.e_bd);
            chk1("badv_we", badv_we, e.e_we);
            if (e.e_we) chk32("badv", badv, e.e_badv);
        end else begin
            chk1("badv_we_eret", badv_we, 1'b0);
        end
        epc_in = v.epc_in;
        @(negedge clk);
        epc_in = 32'hdead_beef;
        chk1("redirect_valid", redirect_valid, 1'b1);
        chk32("redirect_pc", redirect_pc, e.e_rpc);
        chk1("flush_redirect", flush_all, 1'b1);
        chk1("strobe_one_cycle", exc_req | eret_req, 1'b0);
        for (int i = 0; i < v.rdy; i++) begin
            valid_m   = 1'b1;
            exc_flags = 8'h08;
            @(negedge clk);
            chk1("rv_held", redirect_valid, 1'b1);
            chk1("flush_held", flush_all, 1'b1);
            chk1("ignored_event", exc_req | eret_req, 1'b0);
        end
        clear_event();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk1("rv_drop", redirect_valid, 1'b0);
        chk1("flush_drop", flush_all, 1'b0);
        @(negedge clk);
        chk1("idle_quiet", exc_req | eret_req | redirect_valid | stall_all, 1'b0);
    endtask

    initial begin
        int   n;
        int   t;
        logic seen;

        tbl[0]  = mk(1, 32'h8000_0010, 0, 8'h08, 0, 0, 0, 0, 0, 5,
                     0, 5'd8, 32'h8000_0010, 0, 0, 0);
        tbl[1]  = mk(1, 32'h8000_0104, 1, 8'h40, 0, 32'h0000_1003, 0, 0, 3, 0,
                     0, 5'd5, 32'h8000_0100, 1, 1, 32'h0000_1003);
        tbl[2]  = mk(1, 32'h8000_0200, 0, 8'h02, 0, 0, 1, 0, 0, 0,
                     0, 5'd0, 32'h8000_0200, 0, 0, 0);
        tbl[3]  = mk(1, 32'h8000_0300, 0, 8'h80, 0, 0, 0, 32'h8000_2000, 0, 0,
                     1, 5'd0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 32'h8000_0400, 0, 8'h84, 0, 0, 0, 32'h8000_7000, 0, 0,
                     0, 5'd12, 32'h8000_0400, 0, 0, 0);
        tbl[5]  = mk(1, 32'h0040_0000, 0, 8'h01, 32'h0040_0001, 32'h5555, 0, 0, 0, 0,
                     0, 5'd4, 32'h0040_0000, 0, 1, 32'h0040_0001);
        tbl[6]  = mk(1, 32'h8000_0600, 1, 8'h30, 0, 32'h7777, 0, 0, 0, 0,
                     0, 5'd9, 32'h8000_05fc, 1, 0, 0);
        tbl[7]  = mk(1, 32'h0000_0000, 1, 8'h20, 32'h9999, 32'h2222, 0, 0, 0, 0,
                     0, 5'd4, 32'hffff_fffc, 1, 1, 32'h2222);
        tbl[8]  = mk(1, 32'h8000_0800, 0, 8'h06, 0, 0, 0, 0, 0, 0,
                     0, 5'd10, 32'h8000_0800, 0, 0, 0);
        tbl[9]  = mk(1, 32'h8000_0900, 0, 8'h00, 0, 0, 1, 0, 2, 0,
                     0, 5'd0, 32'h8000_0900, 0, 0, 0);
        tbl[10] = mk(1, 32'h8000_0a00, 0, 8'h80, 0, 0, 0, 32'h8000_3000, 1, 0,
                     1, 5'd0, 0, 0, 0, 0);

        resetn         = 1'b0;
        mem_busy       = 1'b0;
        redirect_ready = 1'b0;
        epc_in         = 32'hdead_beef;
        clear_event();
        repeat (2) @(negedge clk);
        chk1("rst_exc_req", exc_req, 1'b0);
        chk1("rst_flush", flush_all, 1'b0);
        chk1("rst_rv", redirect_valid, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk1("idle_after_reset", exc_req | stall_all | flush_all | drain_timeout, 1'b0);

        for (int i = 0; i < 11; i++) run_seq(tbl[i]);
        chk1("no_timeout_yet", drain_timeout, 1'b0);

        // Event sources without valid_m must not start a sequence.
        exc_flags   = 8'h08;
        int_pending = 1'b1;
        seen        = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | exc_req | eret_req | stall_all | flush_all;
        end
        clear_event();
        chk1("invalid_ignored", seen, 1'b0);

        // mem_busy stuck: forced commit after DRAIN_MAX drain cycles.
        valid_m   = 1'b1;
        exc_flags = 8'h08;
        mem_busy  = 1'b1;
        @(negedge clk);
        clear_event();
        n = 0;
        t = 0;
        while (!exc_req && t < 40) begin
            if (stall_all) n++;
            @(negedge clk);
            t++;
        end
        chk32("timeout_stall_cycles", 32'(n), 32'd15);
        chk1("timeout_exc_req", exc_req, 1'b1);
        chk1("drain_timeout_set", drain_timeout, 1'b1);
        mem_busy = 1'b0;
        @(negedge clk);
        chk1("timeout_rv", redirect_valid, 1'b1);
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        @(negedge clk);
        run_seq(tbl[0]);
        chk1("drain_timeout_sticky", drain_timeout, 1'b1);

        // Reset in the middle of DRAIN aborts without any strobe.
        valid_m   = 1'b1;
        exc_flags = 8'h02;
        mem_busy  = 1'b1;
        @(negedge clk);
        clear_event();
        @(negedge clk);
        chk1("pre_reset_stall", stall_all, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk1("arst_stall", stall_all, 1'b0);
        chk1("arst_strobes", exc_req | eret_req | flush_all | redirect_valid, 1'b0);
        chk1("arst_timeout", drain_timeout, 1'b0);
        chk32("arst_code", {27'd0, exc_code}, 32'd0);
        @(negedge clk);
        resetn   = 1'b1;
        mem_busy = 1'b0;
        seen     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | exc_req | eret_req | stall_all | redirect_valid;
        end
        chk1("no_strobe_after_abort", seen, 1'b0);

        // Commit counters count from the reset above.
        run_seq(tbl[0]);
        run_seq(tbl[2]);
        run_seq(tbl[3]);
        run_seq(tbl[5]);
`ifdef EXC_SEQ_STATS_EN
        chk32("exc_count", exc_count, 32'd3);
        chk32("eret_count", {16'd0, eret_count}, 32'd1);
`else
        chk32("exc_count_tied", exc_count, 32'd0);
        chk32("eret_count_tied", {16'd0, eret_count}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
Controller in front of the CP0 register file. It takes exception and interrupt events from the M stage, picks one by fixed priority, and stalls the pipeline while an outstanding data-bus transaction drains. It then issues a single-cycle commit to CP0 (ExcCode/EPC/BD/BadVAddr/EXL, or ERET) and holds a PC redirect until fetch accepts it.

Parameters:
VEC_BASE, 32'hbfc00380, exception vector PC
DRAIN_MAX, 15, max cycles waiting in DRAIN before forced commit (counter width = $clog2(DRAIN_MAX+1))

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
valid_m  in  1  M-stage instruction valid
pc_m  in  32  M-stage PC
bd_m  in  1  M-stage instruction is in a delay slot
exc_flags  in  8  [0]AdEL-fetch [1]RI [2]Ov [3]Sys [4]Bp [5]AdEL-data [6]AdES [7]ERET
badv_if  in  32  faulting fetch address
badv_mem  in  32  faulting data address
int_pending  in  1  CP0 interrupt condition: IE & ~EXL & (IP&IM)!=0
mem_busy  in  1  data-bus transaction outstanding
epc_in  in  32  current CP0 EPC
exc_req  out  1  one-cycle CP0 exception commit strobe
eret_req  out  1  one-cycle CP0 ERET strobe (clears EXL)
exc_code  out  5  Cause.ExcCode
exc_epc  out  32  EPC value
exc_bd  out  1  Cause.BD
badv_we  out  1  write BadVAddr, qualified by exc_req
badv  out  32  BadVAddr value
stall_all  out  1  freeze pipeline
flush_all  out  1  kill all in-flight instructions
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  target PC
redirect_ready  in  1  fetch accepts redirect
drain_timeout  out  1  sticky: a DRAIN timed out

Behaviour:
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT. All outputs are registered. Reset: state=IDLE, all outputs 0, redirect_pc=0.
- Event: valid_m & (int_pending | exc_flags!=0), sampled only in IDLE. Inputs are ignored in every other state.
- Priority, highest first, with ExcCode: Int 0, AdEL-fetch 4, RI 10, Ov 12, Sys 8, Bp 9, AdEL-data 4, AdES 5, ERET (no code). Any exception beats a simultaneous ERET.
- Capture on event: code; epc = bd_m ? pc_m-4 : pc_m (32-bit wrap); bd = bd_m.
  - BadVAddr: AdEL-fetch captures badv_if; AdEL-data and AdES capture badv_mem. badv_we=1 only for these three.
- Transitions:
  - IDLE with event: mem_busy ? DRAIN : COMMIT.
  - DRAIN: stall_all=1, counter increments. Go to COMMIT when mem_busy=0, or when count==DRAIN_MAX (also sets drain_timeout; cleared only by reset).
  - COMMIT: lasts exactly 1 cycle. exc_req=1 (or eret_req=1 for ERET), flush_all=1. redirect_pc = VEC_BASE for exceptions, epc_in sampled this cycle for ERET. Next state REDIRECT.
  - REDIRECT: redirect_valid=1 and flush_all=1 held until redirect_ready. On the handshake cycle go to IDLE with valid/flush deasserted the next cycle. redirect_ready while not in REDIRECT is ignored.
- Latency: event to exc_req is 1 cycle without drain; to first redirect_valid is 2 cycles.
- A reset mid-sequence aborts immediately; no CP0 strobe is emitted.

Optional Feature:
EXC_SEQ_STATS_EN
- Defined: adds output exc_count[31:0], incremented (wrapping) on each exc_req, plus eret_count[15:0] incremented on each eret_req. Both reset to 0.
- Undefined: the ports exist and are tied to 0; no counter logic.

Decomposition:
- Package exc_pkg holds:
  - exc-flag bit index localparams
  - exc_code_t enum (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12)
  - seq_state_t enum
- Sub-module exc_prio_enc: combinational priority encoder taking flags and int_pending, producing hit, is_eret, code, and badv_sel.

Test Plan:
- pc_m=32'h8000_0010, bd_m=0, exc_flags[3]=1, mem_busy=0 -> next cycle exc_req=1, exc_code=8, exc_epc=32'h8000_0010, flush_all=1; following cycle redirect_valid=1, redirect_pc=32'hbfc00380.
- exc_flags[6]=1, bd_m=1, pc_m=32'h8000_0104, badv_mem=32'h1003, mem_busy=1 for 3 cycles -> stall_all=1 for 3 cycles, then exc_code=5, exc_epc=32'h8000_0100, exc_bd=1, badv_we=1, badv=32'h1003.
- int_pending=1 together with exc_flags[1]=1 -> exc_code=0 (interrupt wins). exc_flags=8'h80 (ERET) with epc_in=32'h8000_2000 -> eret_req=1, exc_req=0, redirect_pc=32'h8000_2000.
- mem_busy stuck at 1 -> after 15 DRAIN cycles COMMIT proceeds, drain_timeout=1 and stays 1.
- redirect_ready held 0 for 5 cycles -> redirect_valid and flush_all held; a new exc_flags event during this time is ignored; IDLE after the handshake.
- resetn pulsed low during DRAIN -> all outputs 0 immediately, no exc_req. With EXC_SEQ_STATS_EN defined, three exceptions -> exc_count=3.
